// File: rtl/alu_flag_status_pkg.sv
// Shared ALU definitions: op codes, condition codes, trap FSM states.
// No logic; no latency; no flow control.
// Imported by the flag-status consumer and its condition evaluator.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } trap_state_e;

endpackage

// File: rtl/alu_flag_status_if.sv
// ALU flag bundle plus trap request/ack lines between ALU, flag consumer and control unit.
// Wiring only; no latency.
// Trap request is held until acknowledged; flags have no backpressure.
interface alu_flag_status_if #(parameter int CNT_W = 8);

    logic             flags_valid;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic [3:0]       alu_op;
    logic [3:0]       cond;
    logic             sticky_clr;
    logic             trap_en;
    logic             trap_ack;

    logic [3:0]       nzcv_q;
    logic             cond_true;
    logic             sticky_v;
    logic [CNT_W-1:0] ovf_count;
    logic             trap_req;
    logic [3:0]       trap_op;
    logic             trap_missed;

    modport master (
        output flags_valid, flag_n, flag_z, flag_c, flag_v, alu_op, cond,
               sticky_clr, trap_en, trap_ack,
        input  nzcv_q, cond_true, sticky_v, ovf_count, trap_req, trap_op, trap_missed
    );

    modport slave (
        input  flags_valid, flag_n, flag_z, flag_c, flag_v, alu_op, cond,
               sticky_clr, trap_en, trap_ack,
        output nzcv_q, cond_true, sticky_v, ovf_count, trap_req, trap_op, trap_missed
    );

endinterface

// File: rtl/alu_flag_status_cond_eval.sv
// Evaluates a 4-bit condition code against {N,Z,C,V}.
// Purely combinational, zero latency; no flow control.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] nzcv,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = !z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = !c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = !n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = !v;
            COND_HI: cond_true = c & !z;
            COND_LS: cond_true = !c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = !z & (n == v);
            COND_LE: cond_true = z | (n != v);
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_status.sv
// Registers ALU flags, tracks overflow (sticky bit, saturating count) and raises an overflow trap.
// Flags and trap request appear 1 cycle after the input edge; cond_true is combinational from flags.
// Trap request is held until trap_ack; further overflows while pending only set trap_missed.
module alu_flag_status
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_flag_status_if.slave  bus
);

    logic [3:0]       nzcv_q, nzcv_d;
    logic             sticky_v_q, sticky_v_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic [3:0]       trap_op_q, trap_op_d;
    logic             trap_missed_q, trap_missed_d;
    trap_state_e      state_q, state_d;
    logic             ovf_ev;
    logic             trap_req;

    // Only ADD/SUB overflow counts as an event; other ops still update V in nzcv.
    assign ovf_ev = bus.flags_valid & bus.flag_v & (bus.alu_op[3:1] == OP_ADD[3:1]);

    always_comb begin
        nzcv_d        = nzcv_q;
        sticky_v_d    = sticky_v_q;
        ovf_count_d   = ovf_count_q;
        trap_op_d     = trap_op_q;
        trap_missed_d = trap_missed_q;

        if (bus.flags_valid)
            nzcv_d = {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};

        if (ovf_ev)
            sticky_v_d = 1'b1;
        else if (bus.sticky_clr)
            sticky_v_d = 1'b0;

        if (ovf_ev && (ovf_count_q != {CNT_W{1'b1}}))
            ovf_count_d = ovf_count_q + CNT_W'(1);

        if (ovf_ev && (state_q == REQ))
            trap_missed_d = 1'b1;
        else if (bus.sticky_clr)
            trap_missed_d = 1'b0;

        if (ovf_ev && bus.trap_en && (state_q != REQ))
            trap_op_d = bus.alu_op;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     state_d = bus.trap_ack ? DONE : REQ;
            default: state_d = (ovf_ev && bus.trap_en) ? REQ : IDLE;
        endcase
    end

    always_comb begin
        trap_req = (state_q == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q        <= 4'b0000;
            sticky_v_q    <= 1'b0;
            ovf_count_q   <= '0;
            trap_op_q     <= 4'b0000;
            trap_missed_q <= 1'b0;
        end else begin
            nzcv_q        <= nzcv_d;
            sticky_v_q    <= sticky_v_d;
            ovf_count_q   <= ovf_count_d;
            trap_op_q     <= trap_op_d;
            trap_missed_q <= trap_missed_d;
        end
    end

    cond_eval u_cond_eval (
        .nzcv      (nzcv_q),
        .cond      (bus.cond),
        .cond_true (bus.cond_true)
    );

    assign bus.nzcv_q      = nzcv_q;
    assign bus.sticky_v    = sticky_v_q;
    assign bus.ovf_count   = ovf_count_q;
    assign bus.trap_req    = trap_req;
    assign bus.trap_op     = trap_op_q;
    assign bus.trap_missed = trap_missed_q;

endmodule
